mux_arb_reg: RTL and testbench



---
 rtl/mux_arb_reg.sv | 129 ++++++++++++
 tb/tb_mux_arb_reg.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// mux_arb_reg: N-way arbitrating mux with a registered, valid/ready output slot.
// Requesting channels are arbitrated each cycle; the winner's word is captured
// into the output register and held until the consumer takes it.
// Build option: define MUX_ARB_RR_EN for round-robin arbitration with a rotating
// pointer. Left undefined, the lowest-index requester always wins (no pointer).
module mux_arb_reg #(
    parameter int N = 8,
    parameter int W = 32,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_valid_i,
    input  logic [N*W-1:0]    in_data_i,
    output logic [N-1:0]      in_ready_o,
    output logic              out_valid_o,
    output logic [W-1:0]      out_data_o,
    output logic [SELW-1:0]   out_sel_o,
    input  logic              out_ready_i
);

    logic              out_valid_q, out_valid_d;
    logic [W-1:0]      out_data_q,  out_data_d;
    logic [SELW-1:0]   out_sel_q,   out_sel_d;

    logic              load;
    logic              grant_vld;
    logic [SELW-1:0]   grant_idx;
    logic [W-1:0]      grant_data;

    // The slot may take a new word when it is empty or being drained this cycle.
    assign load = ~out_valid_q | out_ready_i;

`ifdef MUX_ARB_RR_EN
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [2*N-1:0]    req_dbl;
    logic [N-1:0]      req_rot;

    // Modulo-N add of a small offset to a channel index.
    function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                                 input int unsigned     off);
        logic [SELW:0] sum;
        sum = {1'b0, base} + (SELW+1)'(off);
        if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
        return sum[SELW-1:0];
    endfunction

    // Rotate requests so bit k of req_rot is channel (ptr_q + k) mod N.
    assign req_dbl = {in_valid_i, in_valid_i} >> ptr_q;
    assign req_rot = req_dbl[N-1:0];

    // Round-robin pick: first requester at or above ptr_q, wrapping N-1 -> 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (req_rot[k]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(ptr_q, k);
            end
        end
    end

    // Pointer advances past the channel just accepted, otherwise holds.
    always_comb begin
        ptr_d = ptr_q;
        if (load && grant_vld) ptr_d = wrap_add(grant_idx, 1);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    // Fixed-priority pick: lowest-index requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (in_valid_i[k]) begin
                grant_vld = 1'b1;
                grant_idx = SELW'(k);
            end
        end
    end
`endif

    assign grant_data = in_data_i[grant_idx*W +: W];

    // Accept the granted channel only while the slot can load; held low during
    // reset so no producer sees a handshake that the registers will not keep.
    assign in_ready_o = (rst_n && load && grant_vld) ? (N'(1) << grant_idx) : '0;

    // Next state of the output slot: load winner, drain to empty, or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_data_d = grant_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    // Output slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data register is reset too, so a cleared slot reads as all-zero rather than stale data.
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Testbench for mux_arb_reg: directed scenarios plus randomized traffic checked
// against a transaction-level model (winner search by modulo scan).
// Follows the same MUX_ARB_RR_EN define as the design.
module tb_mux_arb_reg;

    localparam int N    = 8;
    localparam int W    = 32;
    localparam int SELW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      in_valid;
    logic [N*W-1:0]    in_data;
    logic [N-1:0]      in_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [SELW-1:0]   out_sel;
    logic              out_ready;
    logic [W-1:0]      ch_data [N];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;

    mux_arb_reg #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = ch_data[i];
    end

    // Model: winning channel for the current requests, or -1.
    function automatic int model_winner();
        for (int j = 0; j < N; j++) begin
            int c;
`ifdef MUX_ARB_RR_EN
            c = (m_ptr + j) % N;
`else
            c = j;
`endif
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w;
        r = '0;
        w = model_winner();
        if ((!m_valid || out_ready) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 0;
    endtask

    task automatic set_idle();
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) ch_data[i] = '0;
    endtask

    // Reset for two cycles; returns at a falling edge with rst_n released.
    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int w;
        bit ld;
        w  = model_winner();
        ld = !m_valid || out_ready;
        @(posedge clk);
        if (ld) begin
            if (w >= 0) begin
                m_valid = 1'b1;
                m_data  = ch_data[w];
                m_sel   = w;
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b d=%h s=%0d exp v=0 d=0 s=0", out_valid, out_data, out_sel);
        end
        // Load a word, then hit reset while it is held.
        in_valid[3] = 1'b1; ch_data[3] = 32'h33; out_ready = 1'b0;
        #1; tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h33) begin
            n_fail++;
            $display("FAIL reset_preload got v=%b d=%h exp v=1 d=00000033", out_valid, out_data);
        end
        in_valid = '1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || in_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_async got v=%b d=%h s=%0d rdy=%b exp all zero", out_valid, out_data, out_sel, in_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) ch_data[i] = W'(i);
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== N'(1)) begin
            n_fail++;
            $display("FAIL reset_first_grant got rdy=%b exp=%b", in_ready, N'(1));
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_first_word got v=%b s=%0d d=%h exp v=1 s=0 d=0", out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        in_valid = 8'b0010_0000; ch_data[5] = 32'hDEADBEEF; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL single_ready got=%b exp=00100000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_sel !== SELW'(5)) begin
            n_fail++;
            $display("FAIL single_out got v=%b d=%h s=%0d exp v=1 d=deadbeef s=5", out_valid, out_data, out_sel);
        end
    endtask

`ifdef MUX_ARB_RR_EN
    task automatic test_round_robin();
        do_reset();
        in_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < N; i++) ch_data[i] = W'(i);
        for (int c = 0; c < 2*N; c++) begin
            #1;
            n_checks++;
            if (in_ready !== (N'(1) << (c % N))) begin
                n_fail++;
                $display("FAIL rr_ready c=%0d got=%b exp=%b", c, in_ready, N'(1) << (c % N));
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== SELW'(c % N) || out_data !== W'(c % N)) begin
                n_fail++;
                $display("FAIL rr_seq c=%0d got v=%b s=%0d d=%h exp s=%0d", c, out_valid, out_sel, out_data, c % N);
            end
        end
    endtask
`else
    task automatic test_fixed_priority();
        do_reset();
        in_valid = 8'b0000_1010; ch_data[1] = 32'h1; ch_data[3] = 32'h3; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 8'b0000_0010) begin
                n_fail++;
                $display("FAIL fp_ready c=%0d got=%b exp=00000010", c, in_ready);
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== SELW'(1) || out_data !== 32'h1) begin
                n_fail++;
                $display("FAIL fp_sel c=%0d got v=%b s=%0d d=%h exp v=1 s=1 d=1", c, out_valid, out_sel, out_data);
            end
        end
    endtask
`endif

    task automatic test_backpressure();
        do_reset();
        in_valid[2] = 1'b1; ch_data[2] = 32'h11; out_ready = 1'b1;
        #1; tick();
        in_valid = '0; in_valid[4] = 1'b1; ch_data[4] = 32'h44; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== '0 || out_valid !== 1'b1 || out_data !== 32'h11 || out_sel !== SELW'(2)) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d got rdy=%b v=%b d=%h s=%0d exp rdy=0 v=1 d=11 s=2",
                         c, in_ready, out_valid, out_data, out_sel);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL bp_release_ready got=%b exp=00010000", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h44 || out_sel !== SELW'(4)) begin
            n_fail++;
            $display("FAIL bp_release_word got v=%b d=%h s=%0d exp v=1 d=44 s=4", out_valid, out_data, out_sel);
        end
        in_valid = '0;
        #1; tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h44) begin
            n_fail++;
            $display("FAIL bp_drain got v=%b d=%h exp v=0 d=44", out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid[7] = 1'b1; ch_data[7] = 32'h77; out_ready = 1'b1;
        #1; tick();
        in_valid = 8'b0100_0001; ch_data[0] = 32'hA0; ch_data[6] = 32'hA6;
        #1;
        n_checks++;
        if (in_ready !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL wrap_ready0 got=%b exp=00000001", in_ready);
        end
        tick();
        n_checks++;
        if (out_sel !== SELW'(0) || out_data !== 32'hA0) begin
            n_fail++;
            $display("FAIL wrap_first got s=%0d d=%h exp s=0 d=a0", out_sel, out_data);
        end
        in_valid[0] = 1'b0;
        #1; tick();
        n_checks++;
        if (out_sel !== SELW'(6) || out_data !== 32'hA6) begin
            n_fail++;
            $display("FAIL wrap_second got s=%0d d=%h exp s=6 d=a6", out_sel, out_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) ch_data[i] = $urandom;
            #1;
            n_checks++;
            if (in_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready());
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_data !== m_data || out_sel !== SELW'(m_sel)) begin
                n_fail++;
                $display("FAIL rand_out c=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d",
                         c, out_valid, out_data, out_sel, m_valid, m_data, m_sel);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        test_reset();
        test_single_channel();
`ifdef MUX_ARB_RR_EN
        test_round_robin();
`else
        test_fixed_priority();
`endif
        test_backpressure();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
